// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request, byte-lane stores, sign/zero-extended loads,
// misalignment errors and a registered one-cycle response. Optional bounds check: DMEM_BOUNDS_CHECK_EN.
module dmem_ctrl #(
  parameter int    ADDR_W    = 14,
  parameter string INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rd_word;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;

  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic              w_capture;
  logic              w_mem_we;
  logic              w_mem_re;
  logic              w_resp_load;
  logic              w_misalign;
  logic              w_oob;
  logic              w_err;
  logic [ADDR_W-1:0] w_index;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  assign w_index    = r_addr[ADDR_W+1:2];
  assign w_misalign = (r_size == 2'b11)
                    | ((r_size == 2'b01) & r_addr[0])
                    | ((r_size == 2'b10) & (|r_addr[1:0]));

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_oob = |r_addr[31:ADDR_W+2];
`else
  // Upper address bits alias onto the array; they are deliberately dropped.
  logic w_unused_addr;
  assign w_unused_addr = |r_addr[31:ADDR_W+2];
  assign w_oob         = 1'b0;
`endif

  assign w_err = w_misalign | w_oob;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_resp_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_mem_we    = ~w_err & r_write;
        w_mem_re    = ~w_err & ~r_write;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_resp_load = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = r_wdata;
    case (r_size)
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // NOTE: the storage array has no reset; contents survive reset and map onto block RAM.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_index][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
    if (w_mem_re) r_rd_word <= r_mem[w_index];
  end

  always_comb begin
    w_byte = r_rd_word[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = r_rd_word[7:0];
      2'b01:   w_byte = r_rd_word[15:8];
      2'b10:   w_byte = r_rd_word[23:16];
      default: w_byte = r_rd_word[31:24];
    endcase
    w_half = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_ext = r_rd_word;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
      if (r_state == S_ACCESS) r_err <= w_err;
      // Response fields are zero outside the single pulse cycle.
      r_resp_valid <= w_resp_load;
      if (w_resp_load) begin
        r_resp_err   <= r_err;
        r_resp_rdata <= (r_err | r_write) ? 32'h0 : w_load_ext;
      end else begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= 32'h0;
      end
    end
  end

endmodule
